// File: rtl/logic_unit_pkg.sv
// Shared types for the registered bitwise logic unit.
package logic_unit_pkg;

  localparam int unsigned LU_OP_W = 3;

  typedef enum logic [LU_OP_W-1:0] {
    LU_AND  = 3'b000,
    LU_OR   = 3'b001,
    LU_XOR  = 3'b010,
    LU_NAND = 3'b011,
    LU_NOR  = 3'b100,
    LU_XNOR = 3'b101,
    LU_NOTA = 3'b110,
    LU_ACCX = 3'b111
  } lu_op_t;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational op decode: a, b, acc_base, op -> result. No state.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   acc_base,
  input  logic [LU_OP_W-1:0] op,
  output logic [WIDTH-1:0]   result
);

  always_comb begin
    result = '0;
    unique case (lu_op_t'(op))
      LU_AND:  result = a & b;
      LU_OR:   result = a | b;
      LU_XOR:  result = a ^ b;
      LU_NAND: result = ~(a & b);
      LU_NOR:  result = ~(a | b);
      LU_XNOR: result = ~(a ^ b);
      LU_NOTA: result = ~a;
      LU_ACCX: result = acc_base ^ a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with XOR checksum accumulator and 1-deep valid/ready output.
// Optional zero/parity flags enabled by defining LU_FLAGS_EN.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned     WIDTH    = 16,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [LU_OP_W-1:0] in_op,
  input  logic               acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic               out_zero,
  output logic               out_parity
);

  logic             valid_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_base;
  logic [WIDTH-1:0] core_result;
  logic             accept;
  logic             accx_accept;

  assign in_ready    = !valid_q || out_ready;
  assign accept      = in_valid && in_ready;
  assign accx_accept = accept && (lu_op_t'(in_op) == LU_ACCX);
  // A clear in the same cycle as an accepted ACCX folds into the new checksum.
  assign acc_base    = acc_clr ? ACC_INIT : acc_q;

  logic_unit_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a        (in_a),
    .b        (in_b),
    .acc_base (acc_base),
    .op       (in_op),
    .result   (core_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      acc_q    <= ACC_INIT;
    end else begin
      if (accept) begin
        valid_q  <= 1'b1;
        result_q <= core_result;
      end else if (out_ready) begin
        valid_q  <= 1'b0;
      end
      if (accx_accept) begin
        acc_q <= core_result;
      end else if (acc_clr) begin
        acc_q <= ACC_INIT;
      end
    end
  end

  assign out_valid  = valid_q;
  assign out_result = result_q;

`ifdef LU_FLAGS_EN
  logic zero_q;
  logic parity_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
    end else if (accept) begin
      zero_q   <= (core_result == '0);
      parity_q <= ^core_result;
    end
  end

  assign out_zero   = zero_q;
  assign out_parity = parity_q;
`else
  assign out_zero   = 1'b0;
  assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe (WIDTH=16, ACC_INIT=0).
module tb_logic_unit_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [2:0]  in_op;
  logic        acc_clr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_zero;
  logic        out_parity;

  int n_cmp;
  int n_err;

`ifdef LU_FLAGS_EN
  localparam bit FlagsOn = 1'b1;
`else
  localparam bit FlagsOn = 1'b0;
`endif

  logic_unit_pipe #(
    .WIDTH    (16),
    .ACC_INIT (16'h0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .acc_clr    (acc_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_parity (out_parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] op, input logic clr);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    acc_clr  = clr;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    n_cmp++;
    if (out_result !== 16'h0000) begin
      n_err++; $display("FAIL reset_result: got %h want 0000", out_result);
    end
    n_cmp++;
    if (out_zero !== 1'b0 || out_parity !== 1'b0) begin
      n_err++; $display("FAIL reset_flags: got z=%b p=%b want 0 0", out_zero, out_parity);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_ops_sweep();
    logic [15:0] exp_res [7];
    exp_res = '{16'h0002, 16'h0003, 16'h0001, 16'hFFFD, 16'hFFFC, 16'hFFFE, 16'hFFFD};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 16'd2, 16'd3, 3'(i), 1'b0);
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_result !== exp_res[i]) begin
        n_err++;
        $display("FAIL op_%0d: got v=%b r=%h want v=1 r=%h", i, out_valid, out_result, exp_res[i]);
      end
    end
    drive(1'b0, 16'd0, 16'd0, 3'd0, 1'b0);
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL drain_valid: got %b want 0", out_valid);
    end
  endtask

  task automatic test_flags();
    out_ready = 1'b1;
    drive(1'b1, 16'd10, 16'd10, 3'b010, 1'b0);
    step();
    n_cmp++;
    if (out_result !== 16'h0000 || out_zero !== FlagsOn || out_parity !== 1'b0) begin
      n_err++;
      $display("FAIL flags_zero: got r=%h z=%b p=%b want r=0000 z=%b p=0",
               out_result, out_zero, out_parity, FlagsOn);
    end
    drive(1'b1, 16'd15, 16'd8, 3'b010, 1'b0);
    step();
    n_cmp++;
    if (out_result !== 16'h0007 || out_zero !== 1'b0 || out_parity !== FlagsOn) begin
      n_err++;
      $display("FAIL flags_parity: got r=%h z=%b p=%b want r=0007 z=0 p=%b",
               out_result, out_zero, out_parity, FlagsOn);
    end
    drive(1'b0, 16'd0, 16'd0, 3'd0, 1'b0);
    step();
  endtask

  task automatic test_accumulate();
    logic [15:0] av [3];
    logic [15:0] bv [3];
    logic [15:0] ev [3];
    av = '{16'd1, 16'd6, 16'd5};
    bv = '{16'd3, 16'd2, 16'd9};
    ev = '{16'h0002, 16'h0006, 16'h000A};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, av[i], bv[i], 3'b111, 1'b0);
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_result !== ev[i]) begin
        n_err++;
        $display("FAIL accx_%0d: got v=%b r=%h want v=1 r=%h", i, out_valid, out_result, ev[i]);
      end
    end
  endtask

  task automatic test_clear_collision();
    out_ready = 1'b1;
    drive(1'b1, 16'hF0F0, 16'h0000, 3'b111, 1'b1);
    step();
    n_cmp++;
    if (out_result !== 16'hF0F0) begin
      n_err++; $display("FAIL clr_collide: got %h want F0F0", out_result);
    end
    // ACCX(0,0) reads back the accumulator.
    drive(1'b1, 16'h0000, 16'h0000, 3'b111, 1'b0);
    step();
    n_cmp++;
    if (out_result !== 16'hF0F0) begin
      n_err++; $display("FAIL clr_collide_acc: got %h want F0F0", out_result);
    end
    drive(1'b0, 16'd0, 16'd0, 3'd0, 1'b0);
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 16'hFF00, 16'h0FF0, 3'b000, 1'b0);
    step();
    drive(1'b1, 16'h1111, 16'h0000, 3'b111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_result !== 16'h0F00 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold_%0d: got v=%b r=%h rdy=%b want v=1 r=0F00 rdy=0",
                 i, out_valid, out_result, in_ready);
      end
      step();
    end
    drive(1'b0, 16'd0, 16'd0, 3'd0, 1'b0);
    out_ready = 1'b1;
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || out_result !== 16'h0F00) begin
      n_err++;
      $display("FAIL bp_release: got v=%b r=%h want v=0 r=0F00", out_valid, out_result);
    end
    drive(1'b1, 16'h0000, 16'h0000, 3'b111, 1'b0);
    step();
    n_cmp++;
    if (out_result !== 16'hF0F0) begin
      n_err++; $display("FAIL bp_acc_stable: got %h want F0F0", out_result);
    end
    drive(1'b0, 16'd0, 16'd0, 3'd0, 1'b0);
    step();
  endtask

  task automatic test_clr_idle();
    out_ready = 1'b1;
    drive(1'b1, 16'd2, 16'd3, 3'b000, 1'b0);
    step();
    drive(1'b0, 16'd0, 16'd0, 3'd0, 1'b1);
    step();
    n_cmp++;
    if (out_result !== 16'h0002) begin
      n_err++; $display("FAIL clr_idle_result: got %h want 0002", out_result);
    end
    drive(1'b1, 16'h0000, 16'h0000, 3'b111, 1'b0);
    step();
    n_cmp++;
    if (out_result !== 16'h0000) begin
      n_err++; $display("FAIL clr_idle_acc: got %h want 0000", out_result);
    end
    drive(1'b0, 16'd0, 16'd0, 3'd0, 1'b0);
    step();
  endtask

  task automatic test_reset_mid_op();
    out_ready = 1'b1;
    drive(1'b1, 16'h1234, 16'h0000, 3'b111, 1'b1);
    step();
    out_ready = 1'b0;
    drive(1'b1, 16'hAAAA, 16'h5555, 3'b001, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_result !== 16'h1234) begin
      n_err++;
      $display("FAIL rst_mid_setup: got v=%b r=%h want v=1 r=1234", out_valid, out_result);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, 16'd0, 16'd0, 3'd0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0 || out_result !== 16'h0000) begin
      n_err++;
      $display("FAIL rst_mid: got v=%b r=%h want v=0 r=0000", out_valid, out_result);
    end
    out_ready = 1'b1;
    drive(1'b1, 16'h0000, 16'h0000, 3'b111, 1'b0);
    step();
    n_cmp++;
    if (out_result !== 16'h0000) begin
      n_err++; $display("FAIL rst_mid_acc: got %h want 0000", out_result);
    end
    drive(1'b0, 16'd0, 16'd0, 3'd0, 1'b0);
    step();
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 16'd0, 16'd0, 3'd0, 1'b0);
    #1;
    test_reset();
    test_ops_sweep();
    test_flags();
    test_accumulate();
    test_clear_collision();
    test_backpressure();
    test_clr_idle();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
